// File: rtl/exec_ctrl_multi.sv
// ---------------------------------------------------------------------------
// exec_ctrl_multi
//
// Execution controller for one compute core. A single start runs N tiles
// back to back. Each tile:
//   FEED  : streams operand-buffer read addresses, one per un-stalled cycle
//   FLUSH : fixed EXTRA_LATENCY-cycle pipeline flush
//   DRAIN : optional DRAIN_CYCLES-cycle partial-sum drain (psu_acc_en)
// A one-cycle tile_done marks each tile end. exec_done accompanies the
// tile_done of the last tile.
//
// Handshake: i_exec_start is a single-cycle request. It is accepted only in
// IDLE; o_busy is high from the first FEED cycle until the cycle after
// exec_done (or after an abort). There is no ready signal: a start seen
// while busy is dropped.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_exec_start      start request (IDLE only)
//   i_exec_abort      abandon current job, back to IDLE next cycle
//   i_stall           freezes the FEED phase only
//   i_psu_acc_en      enable drain phase            (latched at start)
//   i_psu_depth       feed beats per tile minus one (latched at start)
//   i_n_tiles         tile count, 0 means 1         (latched at start)
//   i_rd_base         first read address            (loaded at start)
//   o_buf_valid_en    feed beat issued this cycle
//   o_rd_addr         registered read address
//   o_sys_buf_en      drain-phase enable
//   o_tile_done       end-of-tile pulse
//   o_exec_done       end-of-job pulse
//   o_busy            state != IDLE
//   o_dbg_state       current FSM state (IDLE=0 FEED=1 FLUSH=2 DRAIN=3)
// ---------------------------------------------------------------------------
module exec_ctrl_multi #(
  parameter int PSU_DEPTH_WIDTH = 9,
  parameter int EXTRA_LATENCY   = 51,
  parameter int DRAIN_CYCLES    = 4,
  parameter int TILE_CNT_WIDTH  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_exec_start,
  input  logic                       i_exec_abort,
  input  logic                       i_stall,
  input  logic                       i_psu_acc_en,
  input  logic [PSU_DEPTH_WIDTH-1:0] i_psu_depth,
  input  logic [TILE_CNT_WIDTH-1:0]  i_n_tiles,
  input  logic [PSU_DEPTH_WIDTH-1:0] i_rd_base,
  output logic                       o_buf_valid_en,
  output logic [PSU_DEPTH_WIDTH-1:0] o_rd_addr,
  output logic                       o_sys_buf_en,
  output logic                       o_tile_done,
  output logic                       o_exec_done,
  output logic                       o_busy,
  output logic [1:0]                 o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int FLUSH_W = $clog2(EXTRA_LATENCY + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(EXTRA_LATENCY - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [PSU_DEPTH_WIDTH-1:0] r_beat_cnt;
  logic [FLUSH_W-1:0]         r_flush_cnt;
  logic [DRAIN_W-1:0]         r_drain_cnt;
  logic [TILE_CNT_WIDTH-1:0]  r_tile_cnt;
  logic [TILE_CNT_WIDTH-1:0]  r_last_tile;   // n_tiles_eff - 1
  logic [PSU_DEPTH_WIDTH-1:0] r_depth;
  logic                       r_acc_en;
  logic [PSU_DEPTH_WIDTH-1:0] r_rd_addr;

  logic w_advance;    // beat actually advances address/counters
  logic w_tile_end;   // tile completes this cycle (never on an abort cycle)
  logic w_last_tile;

  assign w_last_tile = (r_tile_cnt == r_last_tile);

  always_comb begin
    w_state_next   = r_state;
    o_buf_valid_en = 1'b0;
    o_sys_buf_en   = 1'b0;
    o_tile_done    = 1'b0;
    o_exec_done    = 1'b0;
    w_advance      = 1'b0;
    w_tile_end     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_exec_start) w_state_next = ST_FEED;
      end
      ST_FEED: begin
        o_buf_valid_en = ~i_stall;
        if (i_exec_abort) begin
          w_state_next = ST_IDLE;
        end else if (!i_stall) begin
          w_advance = 1'b1;
          if (r_beat_cnt == r_depth) w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (i_exec_abort) begin
          w_state_next = ST_IDLE;
        end else if (r_flush_cnt == FLUSH_LAST) begin
          if (r_acc_en) w_state_next = ST_DRAIN;
          else          w_tile_end   = 1'b1;
        end
      end
      ST_DRAIN: begin
        o_sys_buf_en = 1'b1;
        if (i_exec_abort)                    w_state_next = ST_IDLE;
        else if (r_drain_cnt == DRAIN_LAST)  w_tile_end   = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_tile_end) begin
      o_tile_done = 1'b1;
      if (w_last_tile) begin
        o_exec_done  = 1'b1;
        w_state_next = ST_IDLE;
      end else begin
        w_state_next = ST_FEED;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_drain_cnt <= '0;
      r_tile_cnt  <= '0;
      r_last_tile <= '0;
      r_depth     <= '0;
      r_acc_en    <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      r_state <= w_state_next;

      // Phase counters run only inside their phase and sit at zero otherwise,
      // so every FLUSH/DRAIN entry starts from zero without explicit loads.
      r_flush_cnt <= (r_state == ST_FLUSH) ? r_flush_cnt + FLUSH_W'(1) : '0;
      r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;

      if (r_state == ST_IDLE && i_exec_start) begin
        r_depth     <= i_psu_depth;
        r_acc_en    <= i_psu_acc_en;
        r_last_tile <= (i_n_tiles == '0) ? '0 : i_n_tiles - TILE_CNT_WIDTH'(1);
        r_rd_addr   <= i_rd_base;
        r_beat_cnt  <= '0;
        r_tile_cnt  <= '0;
      end

      if (w_advance) begin
        r_rd_addr  <= r_rd_addr + PSU_DEPTH_WIDTH'(1);
        r_beat_cnt <= r_beat_cnt + PSU_DEPTH_WIDTH'(1);
      end

      // Next tile: address keeps running contiguously, only the beat count restarts.
      if (w_tile_end && !w_last_tile) begin
        r_tile_cnt <= r_tile_cnt + TILE_CNT_WIDTH'(1);
        r_beat_cnt <= '0;
      end
    end
  end

  assign o_rd_addr   = r_rd_addr;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_exec_ctrl_multi.sv
// Directed bench for exec_ctrl_multi with EXTRA_LATENCY=3, DRAIN_CYCLES=4.
// Expected beats (address + cycle) and tile-end pulses (cycle + last flag)
// are queued when a job is started and consumed by a negedge monitor.
module tb_exec_ctrl_multi;
  localparam int PDW = 9;
  localparam int TCW = 8;
  localparam int EL  = 3;
  localparam int DC  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           abort_in;
  logic           stall;
  logic           acc;
  logic [PDW-1:0] depth;
  logic [TCW-1:0] ntiles;
  logic [PDW-1:0] base;
  logic           buf_valid_en;
  logic [PDW-1:0] rd_addr;
  logic           sys_buf_en;
  logic           tile_done;
  logic           exec_done;
  logic           busy;
  logic [1:0]     dbg_state;

  exec_ctrl_multi #(
    .PSU_DEPTH_WIDTH(PDW),
    .EXTRA_LATENCY  (EL),
    .DRAIN_CYCLES   (DC),
    .TILE_CNT_WIDTH (TCW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_exec_start  (start),
    .i_exec_abort  (abort_in),
    .i_stall       (stall),
    .i_psu_acc_en  (acc),
    .i_psu_depth   (depth),
    .i_n_tiles     (ntiles),
    .i_rd_base     (base),
    .o_buf_valid_en(buf_valid_en),
    .o_rd_addr     (rd_addr),
    .o_sys_buf_en  (sys_buf_en),
    .o_tile_done   (tile_done),
    .o_exec_done   (exec_done),
    .o_busy        (busy),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int drain_seen   = 0;

  logic [PDW-1:0] exp_q[$];          // expected beat addresses
  int             exp_beat_cyc_q[$]; // expected beat cycles
  int             exp_done_cyc_q[$]; // expected tile_done cycles
  logic           exp_last_q[$];     // expected exec_done with that tile_done

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sys_buf_en) drain_seen++;
      if (buf_valid_en) begin
        if (exp_q.size() == 0) begin
          check("beat_when_none_expected", {31'b0, buf_valid_en}, 32'd0);
        end else begin
          check("beat_addr", {23'b0, rd_addr}, {23'b0, exp_q.pop_front()});
          check("beat_cycle", cyc, exp_beat_cyc_q.pop_front());
        end
      end
      if (tile_done) begin
        if (exp_done_cyc_q.size() == 0) begin
          check("tile_done_when_none_expected", {31'b0, tile_done}, 32'd0);
        end else begin
          check("tile_done_cycle", cyc, exp_done_cyc_q.pop_front());
          check("exec_done_flag", {31'b0, exec_done}, {31'b0, exp_last_q.pop_front()});
        end
      end else if (exec_done) begin
        check("exec_done_without_tile_done", {31'b0, exec_done}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the full no-stall outcome of a job whose start is high in cycle t0.
  task automatic push_job(input int t0, input int d, input int n, input bit a, input int b);
    int n_eff;
    int tl;
    n_eff = (n == 0) ? 1 : n;
    tl    = d + 1 + EL + (a ? DC : 0);
    for (int k = 0; k < n_eff; k++) begin
      for (int i = 0; i <= d; i++) begin
        exp_q.push_back(PDW'(b + k * (d + 1) + i));
        exp_beat_cyc_q.push_back(t0 + 1 + k * tl + i);
      end
      exp_done_cyc_q.push_back(t0 + (k + 1) * tl);
      exp_last_q.push_back(k == n_eff - 1);
    end
  endtask

  // One-cycle start pulse; config inputs are scrambled afterwards so that
  // only latched values can produce the expected behaviour.
  task automatic start_raw(input int d, input int n, input bit a, input int b, output int t0);
    start  = 1'b1;
    depth  = PDW'(d);
    ntiles = TCW'(n);
    acc    = a;
    base   = PDW'(b);
    t0     = cyc;
    tick();
    start  = 1'b0;
    depth  = PDW'($urandom_range(0, 511));
    ntiles = TCW'($urandom_range(0, 255));
    acc    = 1'($urandom_range(0, 1));
    base   = PDW'($urandom_range(0, 511));
  endtask

  task automatic start_job(input int d, input int n, input bit a, input int b, output int t0);
    int t;
    start_raw(d, n, a, b, t);
    push_job(t, d, n, a, b);
    t0 = t;
  endtask

  task automatic wait_idle(input int budget);
    int left;
    left = budget;
    while ((exp_q.size() != 0 || exp_done_cyc_q.size() != 0) && left > 0) begin
      tick();
      left--;
    end
    if (exp_q.size() != 0 || exp_done_cyc_q.size() != 0) begin
      check("job_timeout_pending", exp_q.size() + exp_done_cyc_q.size(), 0);
      exp_q.delete();
      exp_beat_cyc_q.delete();
      exp_done_cyc_q.delete();
      exp_last_q.delete();
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    int t1;
    rst = 1'b1; start = 1'b0; abort_in = 1'b0; stall = 1'b0;
    acc = 1'b0; depth = '0; ntiles = '0; base = '0;
    tick();
    tick();
    @(negedge clk);
    check("rst_buf_valid_en", {31'b0, buf_valid_en}, 32'd0);
    check("rst_sys_buf_en",   {31'b0, sys_buf_en},   32'd0);
    check("rst_tile_done",    {31'b0, tile_done},    32'd0);
    check("rst_exec_done",    {31'b0, exec_done},    32'd0);
    check("rst_busy",         {31'b0, busy},         32'd0);
    check("rst_rd_addr",      {23'b0, rd_addr},      32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: depth 3, one tile, no accumulation; plus a start pulse while busy.
    drain_seen = 0;
    start_job(3, 1, 0, 'h10, t0);
    check("s1_busy_first_feed", {31'b0, busy}, 32'd1);
    tick();
    start = 1'b1; depth = 0; base = 'h55; acc = 1'b1; ntiles = 5;
    tick();
    start = 1'b0;
    wait_idle(100);
    check("s1_busy_after_done", {31'b0, busy}, 32'd0);
    check("s1_rd_addr_final", {23'b0, rd_addr}, 32'h14);
    check("s1_no_drain", drain_seen, 0);

    // 2: same with accumulation, started the cycle after exec_done above.
    drain_seen = 0;
    start_job(3, 1, 1, 'h10, t0);
    wait_idle(100);
    check("s2_cycle_after_done", cyc, t0 + 12);
    check("s2_busy_low", {31'b0, busy}, 32'd0);
    check("s2_drain_cycles", drain_seen, DC);

    // 3: depth 1, three tiles, accumulation.
    drain_seen = 0;
    start_job(1, 3, 1, 'h20, t0);
    wait_idle(100);
    check("s3_rd_addr_final", {23'b0, rd_addr}, 32'h26);
    check("s3_drain_cycles", drain_seen, 3 * DC);

    // 4: stall high on cycles 2-4.
    tick();
    t0 = cyc;
    start = 1'b1; depth = 3; ntiles = 1; acc = 1'b0; base = 'h30;
    exp_q.push_back('h30); exp_beat_cyc_q.push_back(t0 + 1);
    exp_q.push_back('h31); exp_beat_cyc_q.push_back(t0 + 5);
    exp_q.push_back('h32); exp_beat_cyc_q.push_back(t0 + 6);
    exp_q.push_back('h33); exp_beat_cyc_q.push_back(t0 + 7);
    exp_done_cyc_q.push_back(t0 + 10); exp_last_q.push_back(1'b1);
    tick();
    start = 1'b0;
    tick();
    stall = 1'b1;
    check("s4_addr_stall_start", {23'b0, rd_addr}, 32'h31);
    tick();
    tick();
    check("s4_addr_stall_hold", {23'b0, rd_addr}, 32'h31);
    check("s4_no_beat_in_stall", {31'b0, buf_valid_en}, 32'd0);
    tick();
    stall = 1'b0;
    wait_idle(100);
    check("s4_rd_addr_final", {23'b0, rd_addr}, 32'h34);

    // 5: address wrap, n_tiles=0 behaves as one tile.
    start_job(3, 0, 0, 'h1FE, t0);
    wait_idle(100);
    check("s5_rd_addr_wrap", {23'b0, rd_addr}, 32'h002);

    // 6: abort on cycle 3 of a 3-tile job, restart on cycle 5.
    tick();
    start_raw(3, 3, 0, 'h10, t0);
    exp_q.push_back('h10); exp_beat_cyc_q.push_back(t0 + 1);
    exp_q.push_back('h11); exp_beat_cyc_q.push_back(t0 + 2);
    exp_q.push_back('h12); exp_beat_cyc_q.push_back(t0 + 3);
    tick();
    tick();
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    check("s6_busy_after_abort", {31'b0, busy}, 32'd0);
    check("s6_rd_addr_hold", {23'b0, rd_addr}, 32'h12);
    tick();
    start_job(3, 1, 0, 'h10, t1);
    check("s6_restart_offset", t1, t0 + 5);
    wait_idle(100);
    check("s6_rd_addr_final", {23'b0, rd_addr}, 32'h14);

    // Abort landing exactly on an end-of-tile cycle suppresses tile_done.
    start_raw(0, 2, 0, 'h40, t0);
    exp_q.push_back('h40); exp_beat_cyc_q.push_back(t0 + 1);
    tick();
    tick();
    tick();
    abort_in = 1'b1;
    @(negedge clk);
    check("abort_end_tile_cycle", cyc, t0 + 4);
    check("abort_end_no_tile_done", {31'b0, tile_done}, 32'd0);
    check("abort_end_no_exec_done", {31'b0, exec_done}, 32'd0);
    tick();
    abort_in = 1'b0;
    check("abort_end_busy_low", {31'b0, busy}, 32'd0);
    check("abort_end_beats_consumed", exp_q.size(), 0);

    // Full-depth tile: 512 beats, address wraps back to the base.
    tick();
    start_job(511, 1, 0, 'h000, t0);
    wait_idle(700);
    check("full_depth_rd_addr", {23'b0, rd_addr}, 32'h000);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exec_ctrl_multi.md
Name: exec_ctrl_multi

Overview:
- Generalised execution controller for one compute core. Generation 2 of the INT8 exec controller.
- On one start it sequences N back-to-back tiles. Each tile has four parts:
  - a feed phase that streams operand-buffer read addresses;
  - a fixed pipeline flush;
  - an optional partial-sum drain of configurable length;
  - a per-tile completion pulse.
- New capabilities: upstream stall, abort, a latched read base address, and a busy flag.
- Sits between the core top controller and the operand/PSU buffers.

Parameters:
- PSU_DEPTH_WIDTH, 9: width of the per-tile depth and of the read address.
- EXTRA_LATENCY, 51: flush cycles after the last feed beat. Must be ≥1.
- DRAIN_CYCLES, 4: sys_buf_en cycles per tile when accumulation is on. Must be ≥1.
- TILE_CNT_WIDTH, 8: width of the tile-count configuration.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- exec_start, input, 1: start pulse. Accepted only in IDLE.
- exec_abort, input, 1: abandons the current job.
- stall, input, 1: upstream not ready. Freezes the FEED phase only.
- psu_acc_en, input, 1: enables the drain phase. Latched at start.
- psu_depth, input, PSU_DEPTH_WIDTH: tile has psu_depth+1 feed beats. Latched at start.
- n_tiles, input, TILE_CNT_WIDTH: number of tiles. 0 is treated as 1. Latched at start.
- rd_base, input, PSU_DEPTH_WIDTH: first read address. Latched at start.
- buf_valid_en, output, 1: a feed beat is issued this cycle.
- rd_addr, output, PSU_DEPTH_WIDTH: registered read address.
- sys_buf_en, output, 1: drain-phase enable.
- tile_done, output, 1: one-cycle pulse at the end of each tile.
- exec_done, output, 1: one-cycle pulse at the end of the last tile.
- busy, output, 1: high whenever state ≠ IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; all counters go to 0; rd_addr goes to 0; configuration registers go to 0.
  - buf_valid_en, sys_buf_en, tile_done, exec_done and busy are all 0 after reset.
  - rst dominates every other input.
- States: IDLE, FEED, FLUSH, DRAIN.
- IDLE:
  - When exec_start=1, latch the configuration, load rd_addr from rd_base, clear the beat and tile counters, and go to FEED on the next cycle.
  - exec_start is ignored in every other state.
- FEED:
  - buf_valid_en = (state==FEED) & ~stall. This is combinational from the registered state.
  - Each issued beat increments rd_addr and the beat counter.
  - rd_addr wraps modulo 2^PSU_DEPTH_WIDTH.
  - While stall=1, rd_addr and all counters hold.
  - After the beat with beat counter == psu_depth is issued, go to FLUSH.
- FLUSH:
  - Lasts exactly EXTRA_LATENCY cycles. stall is ignored.
  - On the last cycle: if psu_acc_en (latched) is 1, go to DRAIN; otherwise end the tile.
- DRAIN:
  - sys_buf_en=1 for exactly DRAIN_CYCLES cycles. stall is ignored.
  - End the tile on the last drain cycle.
- End of tile (combinational pulse on the last FLUSH or last DRAIN cycle):
  - tile_done=1.
  - If the tile counter == n_tiles_eff-1: exec_done=1 in the same cycle, then go to IDLE.
  - Otherwise: increment the tile counter, clear the beat counter, and go to FEED. rd_addr continues contiguously and is not reloaded.
- Latency with no stall, single tile, start sampled at cycle 0:
  - feed beats occupy cycles 1 to psu_depth+1;
  - exec_done falls on cycle psu_depth+1+EXTRA_LATENCY, plus DRAIN_CYCLES when accumulation is on.
- Abort:
  - exec_abort=1 in any non-IDLE state moves to IDLE on the next cycle.
  - In the abort cycle, buf_valid_en and sys_buf_en are still driven by the current state.
  - No tile_done or exec_done is produced from the abort cycle onward. This holds even when abort coincides with an end-of-tile cycle.
  - rd_addr holds its value.
  - exec_abort in IDLE is ignored. If exec_abort and exec_start are high together in IDLE, start wins.
- Back-to-back jobs: exec_start may arrive in the cycle after exec_done. There is no dead-cycle requirement.
- Arithmetic widths:
  - beat counter is PSU_DEPTH_WIDTH bits;
  - flush counter is clog2(EXTRA_LATENCY+1) bits;
  - drain counter is clog2(DRAIN_CYCLES+1) bits;
  - tile counter is TILE_CNT_WIDTH bits;
  - n_tiles_eff = (n_tiles==0) ? 1 : n_tiles.
- psu_depth = 2^PSU_DEPTH_WIDTH−1 is legal: full-depth tile, no counter overflow.

Test Plan (EXTRA_LATENCY=3, DRAIN_CYCLES=4 unless noted):
1. Start with psu_depth=3, n_tiles=1, acc=0, rd_base=0x10, no stall → buf_valid_en high on cycles 1–4; rd_addr reads 0x10..0x13 then 0x14; tile_done and exec_done on cycle 7; busy covers cycles 1–7; sys_buf_en never asserted.
2. Same as 1 but acc=1 → sys_buf_en high on cycles 8–11; tile_done and exec_done on cycle 11; busy low on cycle 12.
3. psu_depth=1, n_tiles=3, acc=1 → tile_done on cycles 9, 18, 27; exec_done only on 27; rd_addr ends at base+6; 6 beats total.
4. psu_depth=3, stall held high on cycles 2–4 → beats on cycles 1, 5, 6, 7; exec_done on cycle 10; rd_addr frozen during the stall.
5. rd_base=0x1FE, psu_depth=3 (width 9) → addresses 0x1FE, 0x1FF, 0x000, 0x001; final rd_addr 0x002.
6. exec_abort on cycle 3 of a 3-tile job, then exec_start re-asserted on cycle 5 with mode 1 → no tile_done or exec_done from the aborted job; busy low on cycle 4; the second job completes as in scenario 1 timing, offset by 5 cycles. Separately, exec_start pulsed while busy → ignored, no configuration change.
